interval_capture_unit: RTL and testbench
========================================

# interval_capture_unit

Downstream consumer of the signal tracker's interval search. It accepts capture requests, drives the tracker's `recalculate_time`/`value_in` strobe, samples the returned `{start,end}` pair and classifies it. It retries when an interval is still open, feeds the resolved end back to the tracker, and queues tagged interval records in a small FIFO for the trace output stage.

## Interface
- `LOOKBACK_MAX`, 8: largest lookback window; equals the tracker's `BUFFER_WIDTH`.
- `FIFO_DEPTH`, 4: record FIFO entries; power of two, ≥2.
- `TAG_WIDTH`, 32: width of the request/record tag (e.g. instruction address).
- `MAX_RETRY`, 2: number of re-fires allowed when the end is not yet found.
- `clk`  in  1  single clock; all state changes on posedge.
- `rst`  in  1  asynchronous, active-low reset.
- `counter`  in  32 (integer)  current cycle count, shared with the tracker.
- `req_valid`  in  1  capture request present.
- `req_ready`  out  1  unit can accept a request.
- `req_tag`  in  TAG_WIDTH  tag carried into the record.
- `req_lookback`  in  $clog2(LOOKBACK_MAX)+1  window length in cycles.
- `recalculate_time`  out  1  one-cycle strobe to the tracker.
- `value_out`  out  32  window length presented to the tracker's `value_in`.
- `time_in[1:0]`  in  2×32 signed  tracker result `{end,start}`; −1 means not found.
- `update_end`  out  1  one-cycle pulse; tracker loads `previous_end_o`.
- `previous_end_o`  out  32  end time being committed.
- `rec_valid`  out  1  FIFO head valid.
- `rec_ready`  in  1  consumer pops the head when `rec_valid` is also high.
- `rec_tag`, `rec_start`, `rec_end`, `rec_status`  out  TAG_WIDTH/32/32/2  head record fields.
- `drop_count`  out  16  saturating count of BAD_REQ records.

## Operation
- FSM states: IDLE, ARM, FIRE, SAMPLE, WRITE.
- IDLE: `req_ready`=1. On handshake, latch the tag and lookback, and clear the retry count.
  - If lookback is 0 or greater than LOOKBACK_MAX, set status to BAD_REQ (3), increment `drop_count` and go to WRITE.
  - Otherwise go to ARM.
- ARM: drive `value_out`=lookback; `recalculate_time`=0. Go to FIRE.
- FIRE: `recalculate_time`=1 for exactly this cycle; `value_out` holds. Go to SAMPLE.
- SAMPLE: capture `time_in` and classify it:
  - start = −1: status NO_START (1).
  - start ≥ 0 and end ≥ 0: status OK (0).
  - start ≥ 0, end = −1, retries < MAX_RETRY: increment retry; set lookback = min(lookback+1, LOOKBACK_MAX); go to ARM. The window grows by one because `counter` has advanced.
  - start ≥ 0, end = −1, retries exhausted: status NO_END (2).
  - Every case except retry goes to WRITE.
- WRITE: push `{tag,start,end,status}` when the FIFO has space, or when it is full and popped this same cycle. Otherwise stall in WRITE.
  - On push with status OK: `update_end`=1 and `previous_end_o`=end in that same cycle.
  - After the push, go to IDLE.
- FIFO: head is registered. `rec_valid` = count≠0. Pointers wrap modulo FIFO_DEPTH; count width is $clog2(FIFO_DEPTH)+1. Push and pop in the same cycle leaves count unchanged.
- `drop_count` saturates at 16'hFFFF.
- Reset, asynchronous, at any point including mid-FSM:
  - State goes to IDLE and the FIFO is emptied.
  - `recalculate_time`, `update_end`, `rec_valid` and `req_ready` are 0 while `rst`=0.
  - `value_out`, `previous_end_o`, `rec_*` and `drop_count` are 0.
  - `req_ready` rises in the first cycle after `rst` deasserts.

## Timing
- Request accepted at edge T: ARM at T+1, FIRE at T+2 (strobe high T+2..T+3), SAMPLE at T+3, WRITE at T+4. Record visible on `rec_valid` at T+5 when there is no stall.
- Each retry adds 3 cycles (ARM, FIRE, SAMPLE).
- BAD_REQ path: WRITE at T+1, record visible at T+2.
- `recalculate_time` is a registered output, never high two consecutive cycles, and low for at least one cycle before each rise.
- `update_end` is registered, high exactly one cycle, aligned with the FIFO push.
- `req_ready` is 0 in every state except IDLE; there is no request pipelining.

## Test plan
- Tracker returns {start=10, end=12} for lookback 3, tag 0x100 → single `recalculate_time` pulse at T+2, `value_out`=3; record {0x100,10,12,OK} at T+5; `update_end` pulse with `previous_end_o`=12.
- First SAMPLE returns {end=−1, start=20}, second returns end=22 → one retry, second FIRE uses `value_out`=4; record {…,20,22,OK} at T+8.
- End stays −1, MAX_RETRY=2, lookback 7 → `value_out` sequence 7, 8, 8; record status NO_END; no `update_end`.
- Lookback 0 and then lookback 9 → two BAD_REQ records with no strobe; `drop_count`=2.
- `rec_ready`=0 with 4 records queued → fifth request stalls in WRITE with `req_ready`=0. Raise `rec_ready` for one cycle → simultaneous pop and push; count stays 4.
- Assert `rst` during FIRE → `recalculate_time` drops immediately; FIFO empty; `req_ready`=1 one cycle after release.

Source files
------------

// File: rtl/interval_capture_unit.sv
// Record FIFO: stores records in registers; the head entry drives pop_dat.
// Latency: a push is visible on pop_vld one cycle later; a pop takes effect on the clock edge.
// Backpressure: push_rdy is low only when full and no pop is happening in the same cycle.
module icu_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_vld,
  output logic         push_rdy,
  input  logic [W-1:0] push_dat,
  output logic         pop_vld,
  input  logic         pop_rdy,
  output logic [W-1:0] pop_dat
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  assign pop_vld  = (count != '0);
  assign pop      = pop_vld && pop_rdy;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push_rdy = (count != CW'(DEPTH)) || pop;
  assign push     = push_vld && push_rdy;
  assign pop_dat  = mem[rd_ptr];

  // Storage, pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end
endmodule

// Interval capture: strobes the tracker, classifies {start,end}, retries open intervals, queues records.
// Latency: accept to record visible is 5 cycles (+3 per retry); a malformed request takes 2 cycles.
// Backpressure: a full record FIFO without rec_ready holds the FSM in WRITE, keeping req_ready low.
module interval_capture_unit #(
  parameter int LOOKBACK_MAX = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int TAG_WIDTH    = 32,
  parameter int MAX_RETRY    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   counter,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [TAG_WIDTH-1:0]          req_tag,
  input  logic [$clog2(LOOKBACK_MAX):0] req_lookback,
  output logic                          recalculate_time,
  output logic [31:0]                   value_out,
  input  logic [1:0][31:0]              time_in,
  output logic                          update_end,
  output logic [31:0]                   previous_end_o,
  output logic                          rec_valid,
  input  logic                          rec_ready,
  output logic [TAG_WIDTH-1:0]          rec_tag,
  output logic [31:0]                   rec_start,
  output logic [31:0]                   rec_end,
  output logic [1:0]                    rec_status,
  output logic [15:0]                   drop_count
);
  localparam int LBW = $clog2(LOOKBACK_MAX) + 1;
  localparam int RW  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {IDLE, ARM, FIRE, SAMPLE, WRITE} state_t;
  typedef enum logic [1:0] {ST_OK = 2'd0, ST_NO_START = 2'd1, ST_NO_END = 2'd2, ST_BAD_REQ = 2'd3} status_t;

  typedef struct packed {
    logic [TAG_WIDTH-1:0] tag;
    logic [31:0]          t_start;
    logic [31:0]          t_end;
    status_t              status;
  } rec_t;

  state_t               state, state_nx;
  logic [TAG_WIDTH-1:0] tag_q;
  logic [LBW-1:0]       lb_q;
  logic [LBW-1:0]       lb_grow;
  logic [RW-1:0]        retry_q;
  logic [31:0]          start_q;
  logic [31:0]          end_q;
  status_t              status_q;
  logic                 accept;
  logic                 lb_bad;
  logic                 start_found;
  logic                 end_found;
  logic                 do_retry;
  logic                 push_rdy;
  logic                 push;
  rec_t                 wr_rec;
  rec_t                 head;
  logic [$bits(rec_t)-1:0] head_dat;

  // The cycle count is consumed by the tracker; windows here are relative, so it is not needed.
  logic counter_unused;
  assign counter_unused = ^counter;

  assign accept      = (state == IDLE) && req_valid && req_ready;
  assign lb_bad      = (req_lookback == '0) || (int'(req_lookback) > LOOKBACK_MAX);
  // The tracker reports "not found" as -1; any negative value is treated the same way.
  assign start_found = !time_in[0][31];
  assign end_found   = !time_in[1][31];
  assign do_retry    = (state == SAMPLE) && start_found && !end_found && (int'(retry_q) < MAX_RETRY);
  // The window grows by one per retry because counter has moved on, capped at the tracker buffer.
  assign lb_grow     = (int'(lb_q) >= LOOKBACK_MAX) ? LBW'(LOOKBACK_MAX) : lb_q + LBW'(1);
  assign push        = (state == WRITE) && push_rdy;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = lb_bad ? WRITE : ARM;
      ARM:     state_nx = FIRE;
      FIRE:    state_nx = SAMPLE;
      SAMPLE:  state_nx = do_retry ? ARM : WRITE;
      WRITE:   if (push_rdy) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Registered handshake and strobe outputs, derived from the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_ready        <= 1'b0;
      recalculate_time <= 1'b0;
      update_end       <= 1'b0;
      previous_end_o   <= '0;
    end else begin
      req_ready        <= (state_nx == IDLE);
      recalculate_time <= (state_nx == FIRE);
      update_end       <= push && (status_q == ST_OK);
      if (push && (status_q == ST_OK)) previous_end_o <= end_q;
    end
  end

  // Request latch, tracker result capture, classification and drop accounting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_q      <= '0;
      lb_q       <= '0;
      retry_q    <= '0;
      start_q    <= '0;
      end_q      <= '0;
      status_q   <= ST_OK;
      value_out  <= '0;
      drop_count <= '0;
    end else begin
      if (accept) begin
        tag_q   <= req_tag;
        lb_q    <= req_lookback;
        retry_q <= '0;
        if (lb_bad) begin
          status_q <= ST_BAD_REQ;
          start_q  <= '1;
          end_q    <= '1;
          if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end else begin
          value_out <= 32'(req_lookback);
        end
      end
      if (state == SAMPLE) begin
        start_q <= time_in[0];
        end_q   <= time_in[1];
        if (do_retry) begin
          retry_q   <= retry_q + RW'(1);
          lb_q      <= lb_grow;
          value_out <= 32'(lb_grow);
        end else if (!start_found) begin
          status_q <= ST_NO_START;
        end else if (end_found) begin
          status_q <= ST_OK;
        end else begin
          status_q <= ST_NO_END;
        end
      end
    end
  end

  assign wr_rec = '{tag: tag_q, t_start: start_q, t_end: end_q, status: status_q};

  icu_fifo #(
    .W     ($bits(rec_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_rec_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (state == WRITE),
    .push_rdy (push_rdy),
    .push_dat (wr_rec),
    .pop_vld  (rec_valid),
    .pop_rdy  (rec_ready),
    .pop_dat  (head_dat)
  );

  assign head       = rec_t'(head_dat);
  assign rec_tag    = head.tag;
  assign rec_start  = head.t_start;
  assign rec_end    = head.t_end;
  assign rec_status = head.status;
endmodule

// File: tb/tb_interval_capture_unit.sv
// Bench for interval_capture_unit: directed scenarios plus randomized requests against a reference model.
// The bench plays the tracker, answering each strobe with a scripted {start,end} pair.
// Records are consumed immediately except in the FIFO-full and reset scenarios.
module tb_interval_capture_unit;
  localparam int LB_MAX    = 8;
  localparam int MAX_RETRY = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      counter;
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_tag;
  logic [3:0]       req_lookback;
  logic             recalculate_time;
  logic [31:0]      value_out;
  logic [1:0][31:0] time_in;
  logic             update_end;
  logic [31:0]      previous_end_o;
  logic             rec_valid;
  logic             rec_ready;
  logic [31:0]      rec_tag;
  logic [31:0]      rec_start;
  logic [31:0]      rec_end;
  logic [1:0]       rec_status;
  logic [15:0]      drop_count;

  int n_checks = 0;
  int n_fail   = 0;
  int dc       = 0;
  int rsp_s [MAX_RETRY+1];
  int rsp_e [MAX_RETRY+1];

  interval_capture_unit dut (
    .clk              (clk),
    .rst              (rst),
    .counter          (counter),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_tag          (req_tag),
    .req_lookback     (req_lookback),
    .recalculate_time (recalculate_time),
    .value_out        (value_out),
    .time_in          (time_in),
    .update_end       (update_end),
    .previous_end_o   (previous_end_o),
    .rec_valid        (rec_valid),
    .rec_ready        (rec_ready),
    .rec_tag          (rec_tag),
    .rec_start        (rec_start),
    .rec_end          (rec_end),
    .rec_status       (rec_status),
    .drop_count       (drop_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) counter <= counter + 32'd1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic set_rsp(input int s0, input int e0, input int s1, input int e1, input int s2, input int e2);
    rsp_s[0] = s0; rsp_e[0] = e0;
    rsp_s[1] = s1; rsp_e[1] = e1;
    rsp_s[2] = s2; rsp_e[2] = e2;
  endtask

  // Called at a sample point; returns at the sample point just after the accepting edge.
  task automatic send(input logic [31:0] tag, input int lb);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_wait", 32'(req_ready), 32'd1);
    req_valid    = 1'b1;
    req_tag      = tag;
    req_lookback = 4'(lb);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // One full transaction with records consumed immediately, checked against the reference model.
  task automatic run_req(input logic [31:0] tag, input int lb);
    int  win [MAX_RETRY+1];
    int  k, w, st, nfire, lat, fires, upds, rec_cyc;
    bit  bad, seen;
    // Reference: walk the scripted tracker answers with the classification rules.
    bad = (lb == 0) || (lb > LB_MAX);
    k = 0; w = lb; st = 3;
    win[0] = lb;
    if (!bad) begin
      while (1) begin
        if (rsp_s[k] < 0) begin st = 1; break; end
        if (rsp_e[k] >= 0) begin st = 0; break; end
        if (k == MAX_RETRY) begin st = 2; break; end
        k++;
        w = (w + 1 > LB_MAX) ? LB_MAX : w + 1;
        win[k] = w;
      end
    end else begin
      dc++;
    end
    nfire = bad ? 0 : k + 1;
    lat   = bad ? 1 : 4 + 3 * k;
    fires = 0; upds = 0; seen = 0; rec_cyc = 0;

    send(tag, lb);
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c == 1 && !bad) chk("busy_ready", 32'(req_ready), 32'd0);
      if (recalculate_time) begin
        if (fires < nfire) begin
          chk("fire_cycle", c, 1 + 3 * fires);
          chk("window", value_out, win[fires]);
          time_in[0] = rsp_s[fires];
          time_in[1] = rsp_e[fires];
        end else begin
          chk("extra_fire", fires, nfire);
        end
        fires++;
      end
      if (update_end) begin
        upds++;
        chk("upd_cycle", c, lat);
        chk("prev_end", previous_end_o, rsp_e[k]);
      end
      if (rec_valid && !seen) begin
        seen    = 1;
        rec_cyc = c;
        chk("rec_cycle", c, lat);
        chk("rec_tag", rec_tag, tag);
        chk("rec_status", 32'(rec_status), st);
        if (!bad) begin
          chk("rec_start", rec_start, rsp_s[k]);
          chk("rec_end", rec_end, rsp_e[k]);
        end
      end
      if (seen && c > rec_cyc) break;
    end
    chk("rec_seen", 32'(seen), 32'd1);
    chk("fire_count", fires, nfire);
    chk("upd_count", upds, (st == 0) ? 1 : 0);
    chk("drops", 32'(drop_count), dc);
    time_in[0] = -1;
    time_in[1] = -1;
  endtask

  initial begin
    rst = 1'b1; counter = 0;
    req_valid = 1'b0; req_tag = '0; req_lookback = '0;
    rec_ready = 1'b1;
    time_in[0] = -1; time_in[1] = -1;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_recalc", 32'(recalculate_time), 32'd0);
    chk("rst_upd", 32'(update_end), 32'd0);
    chk("rst_rec_valid", 32'(rec_valid), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_value", value_out, 32'd0);
    chk("rst_prev_end", previous_end_o, 32'd0);
    chk("rst_drops", 32'(drop_count), 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", 32'(req_ready), 32'd1);

    // Malformed lookbacks: no strobe, dropped.
    set_rsp(-1, -1, -1, -1, -1, -1);
    run_req(32'hB0, 0);
    run_req(32'hB1, 9);
    chk("drop_two", 32'(drop_count), 32'd2);

    // Clean hit, one retry, exhausted retries, missing start.
    set_rsp(10, 12, -1, -1, -1, -1);
    run_req(32'h100, 3);
    set_rsp(20, -1, 20, 22, -1, -1);
    run_req(32'h200, 3);
    set_rsp(30, -1, 30, -1, 30, -1);
    run_req(32'h300, 7);
    set_rsp(-1, 5, -1, -1, -1, -1);
    run_req(32'h400, 5);

    // Fill the FIFO, stall a fifth record, then pop and push in the same cycle.
    rec_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(32'h500 + i, 0);
    repeat (2) begin @(posedge clk); #1; end
    chk("full_valid", 32'(rec_valid), 32'd1);
    chk("full_head", rec_tag, 32'h500);
    send(32'h504, 0);
    repeat (4) begin @(posedge clk); #1; end
    chk("stall_ready", 32'(req_ready), 32'd0);
    chk("stall_head", rec_tag, 32'h500);
    rec_ready = 1'b1;
    @(posedge clk); #1;
    rec_ready = 1'b0;
    chk("swap_ready", 32'(req_ready), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_valid", 32'(rec_valid), 32'd1);
      chk("drain_tag", rec_tag, 32'h500 + i);
      chk("drain_status", 32'(rec_status), 32'd3);
      rec_ready = 1'b1;
      @(posedge clk); #1;
      rec_ready = 1'b0;
    end
    chk("drain_empty", 32'(rec_valid), 32'd0);
    dc += 5;
    chk("drops_after_fill", 32'(drop_count), dc);

    // Asynchronous reset while the strobe is high, with a record left queued.
    send(32'h600, 0);
    repeat (2) begin @(posedge clk); #1; end
    send(32'h601, 3);
    for (int i = 0; i < 5; i++) begin
      if (recalculate_time) break;
      @(posedge clk); #1;
    end
    chk("fire_seen", 32'(recalculate_time), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_recalc", 32'(recalculate_time), 32'd0);
    chk("mid_rst_rec_valid", 32'(rec_valid), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_value", value_out, 32'd0);
    chk("mid_rst_drops", 32'(drop_count), 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_mid_rst", 32'(req_ready), 32'd1);
    chk("empty_after_mid_rst", 32'(rec_valid), 32'd0);
    dc = 0;
    rec_ready = 1'b1;

    // Randomized requests.
    for (int i = 0; i < 40; i++) begin
      int lb;
      lb = int'($urandom_range(0, 10));
      for (int f = 0; f <= MAX_RETRY; f++) begin
        rsp_s[f] = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 1000));
        rsp_e[f] = ($urandom_range(0, 1) == 0) ? -1 : rsp_s[f] + int'($urandom_range(0, 20));
      end
      run_req($urandom, lb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
